// File: rtl/pc_unit.sv
// Program counter with reset vector, stall, branch/jump redirect and return-address stack.
// Define PC_ALIGN_CHECK_EN to force-align redirect targets and add the sticky misalign output.
module pc_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] ppc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                misalign
`endif
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PC_WIDTH-1:0] INC_W  = PC_WIDTH'(INC);
  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VECTOR);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);
`ifdef PC_ALIGN_CHECK_EN
  localparam int unsigned AB = $clog2(INC);
  localparam logic [PC_WIDTH-1:0] AMASK =
    ~((PC_WIDTH'(1) << AB) - PC_WIDTH'(1));
`endif

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]       sp_q, sp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] top;
  logic [PC_WIDTH-1:0] rd_tgt;
  logic                rd_en;
  logic                push;
`ifdef PC_ALIGN_CHECK_EN
  logic                mis_q, mis_d;
`endif

  // sp_q points at the next free slot; a push when full overwrites the oldest
  always_comb begin
    pc_inc = pc_q + INC_W;
    top    = ras_q[sp_q - PW'(1)];
    pc_d   = pc_q;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    push   = 1'b0;
    rd_en  = 1'b0;
    rd_tgt = pc_inc;
    if (!stall) begin
      if (ret) begin
        if (cnt_q != '0) begin
          rd_en  = 1'b1;
          rd_tgt = top;
          sp_d   = sp_q - PW'(1);
          cnt_d  = cnt_q - CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (jump) begin
        rd_en  = 1'b1;
        rd_tgt = jump_target;
        if (call) begin
          push = 1'b1;
          sp_d = sp_q + PW'(1);
          if (cnt_q == FULL_CNT) err_d = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
      end else if (branch_taken) begin
        rd_en  = 1'b1;
        rd_tgt = branch_target;
      end
`ifdef PC_ALIGN_CHECK_EN
      pc_d = rd_en ? (rd_tgt & AMASK) : pc_inc;
`else
      pc_d = rd_en ? rd_tgt : pc_inc;
`endif
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    mis_d = mis_q;
    if (rd_en && ((rd_tgt & ~AMASK) != '0)) mis_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RST_PC;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q <= mis_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) ras_q[sp_q] <= pc_inc;
  end

  assign ppc       = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_CNT);
  assign ras_err   = err_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign  = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit at default parameters.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        call;
  logic        ret;
  logic [31:0] jump_target;
  logic [31:0] ppc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .call         (call),
    .ret          (ret),
    .jump_target  (jump_target),
    .ppc          (ppc),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_err      (ras_err)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic go_to(input logic [31:0] a);
    branch_taken = 1; branch_target = a;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ppc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", ppc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", ras_full); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ras_err); end
    tick();
    checks++; if (ppc !== 32'h4) begin errors++; $display("FAIL run4 got %h exp %h", ppc, 32'h4); end
    tick();
    checks++; if (ppc !== 32'h8) begin errors++; $display("FAIL run8 got %h exp %h", ppc, 32'h8); end
    tick();
    checks++; if (ppc !== 32'hC) begin errors++; $display("FAIL run12 got %h exp %h", ppc, 32'hC); end
    reset = 0;
    tick();
    checks++; if (ppc !== 32'h0) begin errors++; $display("FAIL rerst got %h exp %h", ppc, 32'h0); end
    reset = 1;
  endtask

  task automatic test_stall_branch();
    do_reset();
    tick();
    tick();
    stall = 1;
    branch_taken = 1; branch_target = 32'h900;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ppc !== 32'h8) begin errors++; $display("FAIL stall%0d got %h exp %h", i, ppc, 32'h8); end
    end
    stall = 0; branch_target = 32'h100;
    tick();
    checks++; if (ppc !== 32'h100) begin errors++; $display("FAIL br got %h exp %h", ppc, 32'h100); end
    idle();
    tick();
    checks++; if (ppc !== 32'h104) begin errors++; $display("FAIL br_inc got %h exp %h", ppc, 32'h104); end
  endtask

  task automatic test_call_ret();
    do_reset();
    go_to(32'h20);
    jump = 1; call = 1; jump_target = 32'h400;
    tick();
    idle();
    checks++; if (ppc !== 32'h400) begin errors++; $display("FAIL call got %h exp %h", ppc, 32'h400); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b exp 0", ras_empty); end
    stall = 1; ret = 1;
    tick();
    stall = 0; ret = 0;
    checks++; if (ppc !== 32'h400 || ras_empty !== 1'b0) begin errors++; $display("FAIL stall_ret got %h/%b exp 400/0", ppc, ras_empty); end
    tick();
    tick();
    checks++; if (ppc !== 32'h408) begin errors++; $display("FAIL run408 got %h exp %h", ppc, 32'h408); end
    ret = 1;
    tick();
    idle();
    checks++; if (ppc !== 32'h24) begin errors++; $display("FAIL ret got %h exp %h", ppc, 32'h24); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL ret_err got %b exp 0", ras_err); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h404; exp_ret[1] = 32'h304;
    exp_ret[2] = 32'h204; exp_ret[3] = 32'h104;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      jump = 1; call = 1; jump_target = ppc + 32'h100;
      tick();
      if (i == 3) begin
        checks++; if (ras_full !== 1'b1 || ras_err !== 1'b0) begin errors++; $display("FAIL full4 got %b/%b exp 1/0", ras_full, ras_err); end
      end
    end
    idle();
    checks++; if (ppc !== 32'h500) begin errors++; $display("FAIL ovf_pc got %h exp %h", ppc, 32'h500); end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", ras_full); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", ras_err); end
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      tick();
      checks++; if (ppc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, ppc, exp_ret[i]); end
    end
    idle();
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b/%b exp 1/0", ras_empty, ras_full); end
  endtask

  task automatic test_underflow_prio();
    do_reset();
    go_to(32'h40);
    ret = 1;
    tick();
    idle();
    checks++; if (ppc !== 32'h44) begin errors++; $display("FAIL udf_pc got %h exp %h", ppc, 32'h44); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL udf_err got %b exp 1", ras_err); end
    go_to(32'h84);
    call = 1;
    tick();
    checks++; if (ppc !== 32'h88 || ras_empty !== 1'b1) begin errors++; $display("FAIL call_nojump got %h/%b exp 88/1", ppc, ras_empty); end
    go_to(32'h84);
    jump = 1; call = 1; jump_target = 32'h200;
    tick();
    idle();
    checks++; if (ppc !== 32'h200) begin errors++; $display("FAIL prio_call got %h exp %h", ppc, 32'h200); end
    ret = 1; branch_taken = 1; branch_target = 32'h300;
    jump = 1; jump_target = 32'h700;
    tick();
    idle();
    checks++; if (ppc !== 32'h88) begin errors++; $display("FAIL prio_ret got %h exp %h", ppc, 32'h88); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL prio_empty got %b exp 1", ras_empty); end
    jump = 1; jump_target = 32'h500; branch_taken = 1; branch_target = 32'h600;
    tick();
    idle();
    checks++; if (ppc !== 32'h500) begin errors++; $display("FAIL jmp_over_br got %h exp %h", ppc, 32'h500); end
  endtask

  task automatic test_wrap_reset();
    go_to(32'hFFFF_FFFC);
    checks++; if (ppc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp %h", ppc, 32'hFFFF_FFFC); end
    tick();
    checks++; if (ppc !== 32'h0) begin errors++; $display("FAIL wrap got %h exp %h", ppc, 32'h0); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL sticky_err got %b exp 1", ras_err); end
    jump = 1; call = 1; jump_target = 32'h1000;
    tick();
    checks++; if (ppc !== 32'h1000 || ras_empty !== 1'b0) begin errors++; $display("FAIL pre_rst got %h/%b exp 1000/0", ppc, ras_empty); end
    reset = 0; stall = 1; jump_target = 32'h2000;
    tick();
    reset = 1;
    idle();
    checks++; if (ppc !== 32'h0) begin errors++; $display("FAIL rst_call_pc got %h exp %h", ppc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rst_call_empty got %b exp 1", ras_empty); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL rst_call_err got %b exp 0", ras_err); end
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_stall_branch();
    test_call_ret();
    test_overflow();
    test_underflow_prio();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain registered PC.
- Adds the following on top of the bare next-value register:
  - reset vector
  - auto-increment
  - stall
  - branch and jump redirect
  - hardware return-address stack (RAS) for call/return
- Sits at the head of the fetch stage. Drives the instruction-memory address and receives redirect requests from decode/execute.

Parameters:
- PC_WIDTH, 32, width of the PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (truncated to PC_WIDTH).
- INC, 4, sequential increment in address units.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- stall  input  1  hold PC and RAS unchanged this cycle.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  PC_WIDTH  branch destination.
- jump  input  1  unconditional redirect to jump_target.
- call  input  1  with jump: push ppc+INC onto RAS, redirect to jump_target.
- ret  input  1  pop RAS, redirect to popped address.
- jump_target  input  PC_WIDTH  jump/call destination.
- ppc  output  PC_WIDTH  current program counter.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky: set on underflow (ret when empty) or overflow (call when full).

Behaviour:
- All state updates on the rising clk edge; ppc is a register output (1-cycle latency from a request to the new ppc).
- Reset (reset==0):
  - ppc=RESET_VECTOR
  - RAS count=0, so ras_empty=1 and ras_full=0
  - ras_err=0
  - stack pointer=0
- Reset overrides every other input, including mid-stall and mid-call.
- Priority when reset==1, highest first:
  1. stall: ppc, RAS and ras_err all hold. Requests presented during stall are dropped, not queued.
  2. ret:
     - if count>0: ppc<=top entry, count-1.
     - if count==0: ppc<=ppc+INC, ras_err<=1.
  3. jump:
     - ppc<=jump_target.
     - if call==1, also push ppc+INC.
     - call without jump is ignored.
  4. branch_taken: ppc<=branch_target.
  5. Default: ppc<=ppc+INC.
- Simultaneous ret and jump/branch: ret wins; the lower-priority redirects are discarded.
- Push when full:
  - Circular overwrite of the oldest entry; count stays RAS_DEPTH.
  - ras_err<=1.
  - The newest RAS_DEPTH return addresses remain correct.
- Arithmetic: ppc+INC is modulo 2^PC_WIDTH. Wrap from all-ones region to low addresses is silent, with no flag.
- Pushed value is ppc+INC of the cycle in which call is accepted (not the target).
- RAS implemented as a RAS_DEPTH-entry register array with a $clog2(RAS_DEPTH)-bit top pointer and a count of $clog2(RAS_DEPTH)+1 bits.
- ras_empty/ras_full are decoded from the registered count. No combinational path from inputs to outputs.
- ras_err clears only on reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Every redirect target (branch_target, jump_target, popped RAS value) has its low $clog2(INC) bits forced to 0 before loading ppc.
  - Extra output port misalign (1 bit, sticky, reset 0) sets when any accepted redirect target had nonzero low bits.
- Undefined:
  - Targets load unmodified.
  - misalign port absent.

Test Plan:
Defaults used throughout: PC_WIDTH=32, INC=4, RAS_DEPTH=4, RESET_VECTOR=0.
1. Reset then free-run: reset=0 for 2 cycles, release -> ppc sequence 0,4,8,12. Hold reset=0 at ppc=12 -> ppc=0 next edge.
2. Stall and branch: at ppc=8 assert stall for 3 cycles -> ppc stays 8. Then branch_taken, branch_target=0x100 -> ppc=0x100, next 0x104.
3. Call/return: at ppc=0x20, call+jump to 0x400 -> ppc=0x400, ras_empty=0. Run to 0x408, ret -> ppc=0x24, ras_empty=1.
4. Overflow: 5 consecutive calls from ppc=0x0,0x100,0x200,0x300,0x400 (all targets +0x100) -> ras_full=1, ras_err=1. 4 rets return 0x404,0x304,0x204,0x104; ras_empty=1.
5. Underflow and priority: ret with empty RAS at ppc=0x40 -> ppc=0x44, ras_err=1. Same-cycle ret+branch_taken with one entry 0x88 -> ppc=0x88, branch ignored.
6. Wrap and reset mid-call: ppc=0xFFFF_FFFC -> next 0x0. Assert reset in the same cycle as call+jump -> ppc=0, ras_empty=1, ras_err=0.
